// File: rtl/aes_block_seq.sv
// Iterative AES block sequencer: a small plaintext FIFO feeding a one-round-per-cycle
// loop around an external combinational round datapath and key lookup.
module aes_block_seq #(
  parameter int NR    = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         key_ready,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [127:0] rf_state,
  output logic         rf_final,
  input  logic [127:0] rf_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} st_e;

  st_e           st;
  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [127:0]  state;
  logic          push, pop;

  // in_ready depends only on the registered count, never on out_ready
  assign in_ready = (count != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (st == IDLE) && (count != '0) && key_ready;
  assign rf_state = state;
  assign out_data = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // rf_final is registered one step ahead so it is high exactly while round == NR in ROUND
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      round     <= '0;
      state     <= '0;
      rf_final  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (pop) begin
            state    <= mem[rd_ptr] ^ round_key;
            round    <= 4'd1;
            rf_final <= (LAST == 4'd1);
            st       <= ROUND;
          end
        end
        ROUND: begin
          state <= rf_result;
          if (round == LAST) begin
            st        <= DONE;
            rf_final  <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            round    <= round + 4'd1;
            rf_final <= ((round + 4'd1) == LAST);
          end
        end
        DONE: begin
          if (out_ready) begin
            st        <= IDLE;
            round     <= '0;
            out_valid <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_block_seq.sv
// Bench for aes_block_seq: a behavioural AES round/key-schedule model drives the
// external datapath ports, and a whole-block AES reference predicts every ciphertext.
module tb_aes_block_seq;
  localparam int NRA = 10;
  localparam int NRB = 14;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_in_valid, a_in_ready, a_key_ready, a_rf_final, a_out_valid, a_out_ready;
  logic [3:0] a_round;
  logic [127:0] a_in_data, a_round_key, a_rf_state, a_rf_result, a_out_data;
  logic b_in_valid, b_in_ready, b_key_ready, b_rf_final, b_out_valid, b_out_ready;
  logic [3:0] b_round;
  logic [127:0] b_in_data, b_round_key, b_rf_state, b_rf_result, b_out_data;

  logic [127:0] rk_a [0:15];
  logic [127:0] rk_b [0:15];
  logic [127:0] sb_a [$];
  logic [127:0] got_a [$];
  int n_cmp = 0;
  int n_bad = 0;

  aes_block_seq #(.NR(NRA), .DEPTH(DEP)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .key_ready(a_key_ready), .round(a_round), .round_key(a_round_key), .rf_state(a_rf_state),
    .rf_final(a_rf_final), .rf_result(a_rf_result), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data));

  aes_block_seq #(.NR(NRB), .DEPTH(DEP)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .key_ready(b_key_ready), .round(b_round), .round_key(b_round_key), .rf_state(b_rf_state),
    .rf_final(b_rf_final), .rf_result(b_rf_result), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data));

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, a, b;
    p = 8'h00; a = x; b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, sq, r;
    inv = 8'h01; sq = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    r = inv ^ ((inv << 1) | (inv >> 7)) ^ ((inv << 2) | (inv >> 6))
            ^ ((inv << 3) | (inv >> 5)) ^ ((inv << 4) | (inv >> 4)) ^ 8'h63;
    return r;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr, input bit to_b);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        tmp = w[i-1];
        if (i % nk == 0) begin
          tmp = {tmp[23:0], tmp[31:24]};
          tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rc, 24'h0};
          rc  = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
        end
        w[i] = w[i-nk] ^ tmp;
      end
    end
    for (int r = 0; r <= nr; r++) begin
      if (to_b) rk_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else      rk_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // Whole-block encryption: AddRoundKey, NR-1 full rounds, final round without MixColumns
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input bit use_b);
    logic [127:0] s;
    int nr;
    nr = use_b ? NRB : NRA;
    s  = pt ^ (use_b ? rk_b[0] : rk_a[0]);
    for (int r = 1; r <= nr; r++) s = aes_round(s, use_b ? rk_b[r] : rk_a[r], r == nr);
    return s;
  endfunction

  always_comb begin
    a_round_key = rk_a[a_round];
    a_rf_result = aes_round(a_rf_state, a_round_key, a_rf_final);
    b_round_key = rk_b[b_round];
    b_rf_result = aes_round(b_rf_state, b_round_key, b_rf_final);
  end

  // Observes DUT A every cycle: pop times, pop-to-pop gaps, latency, rf_final legality
  int mon_cyc = 0, a_pop_cyc = -1000, a_last_lat = 0, a_min_gap = 1000;
  int a_lat_err = 0, a_rff_err = 0, a_pops = 0, a_emits = 0;
  logic [3:0] a_prev_round = '0;
  logic a_prev_ov = 1'b0;
  always @(negedge clk) begin
    mon_cyc++;
    if (a_round == 4'd1 && a_prev_round != 4'd1) begin
      if (mon_cyc - a_pop_cyc < a_min_gap) a_min_gap = mon_cyc - a_pop_cyc;
      a_pop_cyc = mon_cyc;
      a_pops++;
    end
    if (a_out_valid && !a_prev_ov) begin
      a_last_lat = mon_cyc - a_pop_cyc + 1;
      if (a_last_lat != NRA + 1) a_lat_err++;
      a_emits++;
    end
    if (a_rf_final !== (a_round == 4'(NRA) && !a_out_valid)) a_rff_err++;
    a_prev_round = a_round;
    a_prev_ov    = a_out_valid;
  end

  task automatic step_a();
    #1;
    if (a_in_valid && a_in_ready) sb_a.push_back(aes_ref(a_in_data, 1'b0));
    if (a_out_valid && a_out_ready) got_a.push_back(a_out_data);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp += 6;
    if (a_round !== 4'd0) begin n_bad++; $display("FAIL rst_round: got %0d want 0", a_round); end
    if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
    if (a_out_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", a_out_data); end
    if (a_rf_state !== '0) begin n_bad++; $display("FAIL rst_rf_state: got %h want 0", a_rf_state); end
    if (a_rf_final !== 1'b0) begin n_bad++; $display("FAIL rst_rf_final: got %b want 0", a_rf_final); end
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_in_ready: got %b/%b want 1/1", a_in_ready, b_in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_fips128();
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, NRA, 1'b0);
    a_key_ready = 1'b1; a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 128'h3243f6a8885a308d313198a2e0370734;
    step_a();
    a_in_valid = 1'b0;
    for (int i = 0; i < 40 && !a_out_valid; i++) step_a();
    #1;
    n_cmp += 4;
    if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL fips_timeout: out_valid %b want 1", a_out_valid); end
    if (a_out_data !== 128'h3925841d02dc09fbdc118597196a0b32) begin
      n_bad++; $display("FAIL fips_data: got %h want 3925841d02dc09fbdc118597196a0b32", a_out_data);
    end
    if (a_last_lat != NRA + 1) begin n_bad++; $display("FAIL fips_latency: got %0d want %0d", a_last_lat, NRA + 1); end
    if (a_round !== 4'(NRA)) begin n_bad++; $display("FAIL fips_done_round: got %0d want %0d", a_round, NRA); end
    a_out_ready = 1'b1;
    step_a();
    a_out_ready = 1'b0;
    n_cmp++;
    if (got_a.size() != 1 || sb_a.size() != 1 || got_a[0] !== sb_a[0]) begin
      n_bad++; $display("FAIL fips_model: got %0d blocks want 1 matching model", got_a.size());
    end
    got_a.delete(); sb_a.delete();
  endtask

  task automatic test_fifo_full();
    logic [127:0] d [5];
    int blk, n0;
    for (int i = 0; i < 5; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
    a_key_ready = 1'b0; a_out_ready = 1'b1; blk = 0;
    for (int c = 0; c < 8; c++) begin
      a_in_valid = (blk < 5); a_in_data = d[blk % 5];
      n0 = sb_a.size(); step_a();
      if (sb_a.size() > n0) blk++;
    end
    n_cmp += 3;
    if (blk != 4) begin n_bad++; $display("FAIL full_accepted: got %0d want 4", blk); end
    if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b want 0", a_in_ready); end
    if (a_round !== 4'd0) begin n_bad++; $display("FAIL full_no_pop: round %0d want 0", a_round); end
    a_key_ready = 1'b1;
    for (int c = 0; c < 300 && !(blk == 5 && got_a.size() == 5); c++) begin
      a_in_valid = (blk < 5); a_in_data = d[blk % 5];
      n0 = sb_a.size(); step_a();
      if (sb_a.size() > n0) blk++;
    end
    a_in_valid = 1'b0;
    n_cmp++;
    if (got_a.size() != 5 || sb_a.size() != 5) begin
      n_bad++; $display("FAIL full_count: got %0d/%0d want 5/5", got_a.size(), sb_a.size());
    end
    while (got_a.size() > 0 && sb_a.size() > 0) begin
      n_cmp++;
      if (got_a[0] !== sb_a[0]) begin n_bad++; $display("FAIL full_order: got %h want %h", got_a[0], sb_a[0]); end
      void'(got_a.pop_front()); void'(sb_a.pop_front());
    end
    got_a.delete(); sb_a.delete();
  endtask

  task automatic test_key_wait();
    a_key_ready = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1'b1; a_in_data = {$urandom, $urandom, $urandom, $urandom};
      step_a();
    end
    a_in_valid = 1'b0;
    repeat (5) step_a();
    n_cmp++;
    if (a_round !== 4'd0) begin n_bad++; $display("FAIL keywait_hold: round %0d want 0", a_round); end
    a_key_ready = 1'b1;
    step_a();
    n_cmp++;
    if (a_round !== 4'd1) begin n_bad++; $display("FAIL keywait_first_pop: round %0d want 1", a_round); end
    for (int c = 0; c < 100 && got_a.size() < 2; c++) step_a();
    n_cmp++;
    if (got_a.size() != 2 || sb_a.size() != 2) begin
      n_bad++; $display("FAIL keywait_count: got %0d/%0d want 2/2", got_a.size(), sb_a.size());
    end
    while (got_a.size() > 0 && sb_a.size() > 0) begin
      n_cmp++;
      if (got_a[0] !== sb_a[0]) begin n_bad++; $display("FAIL keywait_order: got %h want %h", got_a[0], sb_a[0]); end
      void'(got_a.pop_front()); void'(sb_a.pop_front());
    end
    got_a.delete(); sb_a.delete();
  endtask

  task automatic test_stall();
    logic [127:0] od;
    int pops0, unstable;
    a_key_ready = 1'b1; a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = {$urandom, $urandom, $urandom, $urandom};
    step_a();
    a_in_valid = 1'b0;
    for (int i = 0; i < 40 && !a_out_valid; i++) step_a();
    #1;
    n_cmp++;
    if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_timeout: out_valid %b want 1", a_out_valid); end
    od = a_out_data; pops0 = a_pops; unstable = 0;
    for (int c = 0; c < 20; c++) begin
      a_in_valid = 1'b1; a_in_data = {$urandom, $urandom, $urandom, $urandom};
      step_a();
      if (a_out_valid !== 1'b1 || a_out_data !== od || a_round !== 4'(NRA)) unstable++;
    end
    a_in_valid = 1'b0;
    #1;
    n_cmp += 4;
    if (unstable != 0) begin n_bad++; $display("FAIL stall_stable: %0d unstable cycles want 0", unstable); end
    if (a_pops != pops0) begin n_bad++; $display("FAIL stall_no_pop: %0d pops want 0", a_pops - pops0); end
    if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_fill: in_ready %b want 0", a_in_ready); end
    if (sb_a.size() != 5) begin n_bad++; $display("FAIL stall_accepted: %0d blocks want 5", sb_a.size()); end
    a_out_ready = 1'b1;
    for (int c = 0; c < 300 && got_a.size() < sb_a.size(); c++) step_a();
    n_cmp++;
    if (got_a.size() != sb_a.size()) begin
      n_bad++; $display("FAIL stall_count: got %0d want %0d", got_a.size(), sb_a.size());
    end
    while (got_a.size() > 0 && sb_a.size() > 0) begin
      n_cmp++;
      if (got_a[0] !== sb_a[0]) begin n_bad++; $display("FAIL stall_order: got %h want %h", got_a[0], sb_a[0]); end
      void'(got_a.pop_front()); void'(sb_a.pop_front());
    end
    got_a.delete(); sb_a.delete();
  endtask

  task automatic test_random();
    expand({$urandom, $urandom, $urandom, $urandom, 128'h0}, 4, NRA, 1'b0);
    for (int c = 0; c < 700; c++) begin
      a_in_valid  = ($urandom_range(0, 2) != 0);
      a_in_data   = {$urandom, $urandom, $urandom, $urandom};
      a_key_ready = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 9) < 7);
      step_a();
    end
    a_in_valid = 1'b0; a_key_ready = 1'b1; a_out_ready = 1'b1;
    for (int c = 0; c < 400 && got_a.size() < sb_a.size(); c++) step_a();
    #1;
    n_cmp += 4;
    if (got_a.size() != sb_a.size()) begin
      n_bad++; $display("FAIL rand_count: got %0d want %0d", got_a.size(), sb_a.size());
    end
    if (a_min_gap < NRA + 2) begin n_bad++; $display("FAIL rand_pop_gap: min %0d want >= %0d", a_min_gap, NRA + 2); end
    if (a_lat_err != 0) begin n_bad++; $display("FAIL rand_latency: %0d bad latencies want 0", a_lat_err); end
    if (a_rff_err != 0) begin n_bad++; $display("FAIL rand_rf_final: %0d bad cycles want 0", a_rff_err); end
    while (got_a.size() > 0 && sb_a.size() > 0) begin
      n_cmp++;
      if (got_a[0] !== sb_a[0]) begin n_bad++; $display("FAIL rand_data: got %h want %h", got_a[0], sb_a[0]); end
      void'(got_a.pop_front()); void'(sb_a.pop_front());
    end
    got_a.delete(); sb_a.delete();
  endtask

  task automatic test_reset_mid();
    int emits0;
    a_key_ready = 1'b1; a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_data = {$urandom, $urandom, $urandom, $urandom};
      step_a();
    end
    a_in_valid = 1'b0;
    for (int c = 0; c < 30 && a_round != 4'd5; c++) step_a();
    n_cmp++;
    if (a_round !== 4'd5) begin n_bad++; $display("FAIL rstmid_reach: round %0d want 5", a_round); end
    rst = 1'b1;
    step_a();
    rst = 1'b0;
    #1;
    emits0 = a_emits;
    n_cmp += 3;
    if (a_round !== 4'd0) begin n_bad++; $display("FAIL rstmid_round: got %0d want 0", a_round); end
    if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b want 0", a_out_valid); end
    if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", a_in_ready); end
    repeat (60) step_a();
    #1;
    n_cmp++;
    if (a_emits != emits0 || got_a.size() != 0) begin
      n_bad++; $display("FAIL rstmid_discard: %0d emitted want 0", a_emits - emits0 + got_a.size());
    end
    got_a.delete(); sb_a.delete();
  endtask

  task automatic test_nr14();
    logic [127:0] pt;
    int p, lat, fin_cnt, fin_err, c;
    pt = 128'h00112233445566778899aabbccddeeff;
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, NRB, 1'b1);
    b_key_ready = 1'b1; b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = pt;
    @(negedge clk);
    b_in_valid = 1'b0;
    p = -100; fin_cnt = 0; fin_err = 0; c = 0;
    for (c = 0; c < 60; c++) begin
      @(negedge clk);
      if (b_round == 4'd1 && p < 0) p = c;
      if (b_rf_final) fin_cnt++;
      if (b_rf_final !== (b_round == 4'd14 && !b_out_valid)) fin_err++;
      if (b_out_valid) break;
    end
    lat = c - p + 1;
    n_cmp += 5;
    if (b_out_valid !== 1'b1) begin n_bad++; $display("FAIL nr14_timeout: out_valid %b want 1", b_out_valid); end
    if (lat != NRB + 1) begin n_bad++; $display("FAIL nr14_latency: got %0d want %0d", lat, NRB + 1); end
    if (fin_cnt != 1 || fin_err != 0) begin
      n_bad++; $display("FAIL nr14_rf_final: %0d high cycles, %0d wrong, want 1/0", fin_cnt, fin_err);
    end
    if (b_out_data !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
      n_bad++; $display("FAIL nr14_data: got %h want 8ea2b7ca516745bfeafc49904b496089", b_out_data);
    end
    if (b_out_data !== aes_ref(pt, 1'b1)) begin
      n_bad++; $display("FAIL nr14_model: got %h want %h", b_out_data, aes_ref(pt, 1'b1));
    end
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    n_cmp++;
    if (b_out_valid !== 1'b0 || b_round !== 4'd0) begin
      n_bad++; $display("FAIL nr14_release: out_valid %b round %0d want 0/0", b_out_valid, b_round);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin rk_a[i] = '0; rk_b[i] = '0; end
    a_in_valid = 1'b0; a_in_data = '0; a_key_ready = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_key_ready = 1'b0; b_out_ready = 1'b0;
    test_reset();
    test_fips128();
    test_fifo_full();
    test_key_wait();
    test_stall();
    test_random();
    test_reset_mid();
    test_nr14();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
